inv_sub_bytes_seq: RTL and testbench
====================================

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL provide port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL provide port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL provide port `in_valid`: input, 1 bit, source presents a 128-bit state.
REQ-005 The block SHALL provide port `in_ready`: output, 1 bit, block can accept a state.
REQ-006 The block SHALL provide port `in_state`: input, 128 bits, inverse-shifted state array.
REQ-007 The block SHALL provide port `abort`: input, 1 bit, synchronous cancel of the operation in flight.
REQ-008 The block SHALL provide port `out_valid`: output, 1 bit, result available.
REQ-009 The block SHALL provide port `out_ready`: input, 1 bit, sink accepts the result.
REQ-010 The block SHALL provide port `out_state`: output, 128 bits, inverse-substituted state array.
REQ-011 The block SHALL provide port `busy`: output, 1 bit, high in the SUB state.
REQ-012 The block SHALL provide port `word_idx`: output, 2 bits, 32-bit word currently being substituted.

Function
REQ-013 The block SHALL time-share exactly four `inverse_s_box` instances (one 32-bit lane) across the four words of the state; no other S-box instances are permitted.
REQ-014 The FSM SHALL have exactly three states: IDLE, SUB and DONE.
REQ-015 `in_ready` SHALL be 1 in IDLE and 0 in SUB and DONE.
REQ-016 An input handshake (`in_valid` & `in_ready` at an edge) SHALL capture `in_state` into an internal register, clear `word_idx` to 0 and move the FSM to SUB; `in_state` is don't-care afterwards.
REQ-017 In SUB, each cycle SHALL feed captured bits [word_idx*32 +: 32] to the lane, write the lane output into result bits [word_idx*32 +: 32] at the next edge, then increment `word_idx`.
REQ-018 Each byte of the result SHALL be the inverse S-box of the same byte position of the input; the mapping SHALL be byte position i to byte position i, for all 16 bytes.
REQ-019 At the edge that writes word 3, the FSM SHALL move to DONE and `word_idx` SHALL wrap to 0.
REQ-020 Latency SHALL be exactly 4 clocks from the input-handshake edge to `out_valid` = 1.
REQ-021 `out_valid` SHALL be 1 only in DONE.
REQ-022 `out_state` SHALL be updated only in DONE, or only when the full result is written; in either case it SHALL be stable while `out_valid` = 1.
REQ-023 In DONE, `out_valid` & `out_ready` at an edge SHALL return the FSM to IDLE; a new input SHALL be accepted no earlier than the following edge.
REQ-024 In DONE with `out_ready` = 0, the FSM SHALL hold DONE and `out_state` indefinitely.
REQ-025 `abort` = 1 at an edge in SUB or DONE SHALL force IDLE, set `word_idx` to 0 and drop `out_valid`; `out_state` SHALL retain its prior value.
REQ-026 `abort` SHALL take priority over both handshakes in the same cycle.
REQ-027 `abort` = 1 in IDLE SHALL suppress acceptance in that cycle.
REQ-028 `busy` SHALL equal (state == SUB).

Reset
REQ-029 While `rst` = 1 and on its deassertion: FSM = IDLE, `word_idx` = 0, `out_valid` = 0, `out_state` = 0, internal registers = 0, `busy` = 0, `in_ready` = 1.
REQ-030 Reset asserted mid-SUB or mid-DONE SHALL immediately discard the operation, with no partial result visible.
REQ-031 The first input handshake after reset SHALL behave per REQ-016.

Verification
REQ-032 Accept `in_state` = 128'h0 with `out_ready` = 1 -> `out_valid` exactly 4 clocks later, `out_state` = 128'h5252…52 (16 bytes of 0x52), IDLE next cycle.
REQ-033 Accept `in_state` = {16{8'h63}}, then `in_state` = {16{8'hFF}}, `out_ready` held 0 for 10 cycles -> `out_state` = 128'h0 stable throughout, `in_ready` = 0, second state not accepted; then `out_ready` = 1 -> accept, `out_state` = {16{8'h7D}}.
REQ-034 Per-byte position check, `in_state` = 128'h000102…0F -> byte 15 (MSB) = 0x52, byte 14 = 0x09, byte 0 (LSB) = 0xFB; `word_idx` observed 0,1,2,3 across the SUB cycles.
REQ-035 Assert `abort` in the 3rd SUB cycle -> IDLE next edge, `out_valid` never 1, `out_state` keeps the previous result; `abort` and `in_valid` both 1 in IDLE -> no acceptance.
REQ-036 Assert `rst` mid-SUB for a partial clock (asynchronous) -> all outputs take the REQ-029 values immediately; a subsequent 128'h0 input yields {16{8'h52}}.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes over a 128-bit state. A single 32-bit
// lane of four inverse S-boxes is time-shared across the four state words,
// one word per clock. A result appears 4 clocks after the input handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  source presents a 128-bit state
//   in_ready  block can accept a state (IDLE only)
//   in_state  inverse-shifted state array
//   abort     synchronous cancel of the operation in flight
//   out_valid result available (DONE only)
//   out_ready sink accepts the result
//   out_state inverse-substituted state array
//   busy      high while substituting (SUB)
//   word_idx  32-bit word currently being substituted

// Inverse S-box: one byte in, one byte out, pure lookup.
module inverse_s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   word_idx
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LANES   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           word_idx_q, word_idx_d;
  logic [STATE_W-1:0]   in_reg_q, in_reg_d;
  // Words 0..2 accumulate here; word 3 goes straight into out_state.
  logic [3*WORD_W-1:0]  res_q, res_d;
  logic [STATE_W-1:0]   out_state_q, out_state_d;
  logic [WORD_W-1:0]    lane_in_c;
  logic [WORD_W-1:0]    lane_out_c;

  // Select the captured word for the shared lane.
  always_comb begin
    lane_in_c = in_reg_q[WORD_W-1:0];
    unique case (word_idx_q)
      2'd0: lane_in_c = in_reg_q[31:0];
      2'd1: lane_in_c = in_reg_q[63:32];
      2'd2: lane_in_c = in_reg_q[95:64];
      2'd3: lane_in_c = in_reg_q[127:96];
      default: lane_in_c = in_reg_q[31:0];
    endcase
  end

  // Shared 32-bit lane; byte position is preserved through the lane.
  for (genvar b = 0; b < LANES; b++) begin : g_lane
    inverse_s_box u_sbox (
      .in_byte  (lane_in_c[8*b +: 8]),
      .out_byte (lane_out_c[8*b +: 8])
    );
  end

  // Next-state and datapath update; abort beats both handshakes.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    in_reg_d    = in_reg_q;
    res_d       = res_q;
    out_state_d = out_state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          in_reg_d   = in_state;
          word_idx_d = 2'd0;
          state_d    = SUB;
        end
      end
      SUB: begin
        if (abort) begin
          word_idx_d = 2'd0;
          state_d    = IDLE;
        end else begin
          unique case (word_idx_q)
            2'd0: res_d[31:0]  = lane_out_c;
            2'd1: res_d[63:32] = lane_out_c;
            2'd2: res_d[95:64] = lane_out_c;
            2'd3: begin
              out_state_d = {lane_out_c, res_q};
              state_d     = DONE;
            end
            default: res_d = res_q;
          endcase
          // Wraps 3 -> 0 on the final word.
          word_idx_d = word_idx_q + 2'd1;
        end
      end
      DONE: begin
        if (abort) begin
          word_idx_d = 2'd0;
          state_d    = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        word_idx_d = 2'd0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_idx_q  <= 2'd0;
      in_reg_q    <= '0;
      res_q       <= '0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      in_reg_q    <= in_reg_d;
      res_q       <= res_d;
      out_state_q <= out_state_d;
    end
  end

  // Status outputs decode the state register directly.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SUB);
  assign out_valid = (state_q == DONE);
  assign word_idx  = word_idx_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq. The reference inverse S-box is
// derived from GF(2^8) arithmetic (forward S-box, then inverted).
module tb_inv_sub_bytes_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   word_idx;

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .word_idx  (word_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   inv_tbl [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // Forward S-box: affine transform of the multiplicative inverse.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = inv; r = inv;
    for (int k = 0; k < 4; k++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_tbl[d[8*i +: 8]];
    return o;
  endfunction

  // Monitor: pops the scoreboard on each output handshake, checks hold stability.
  logic         held = 1'b0;
  logic [127:0] held_state;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held) chk("hold_stable", out_state, held_state);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", out_state);
        end else begin
          chk("result", out_state, exp_q.pop_front());
        end
        held <= 1'b0;
      end else begin
        held       <= 1'b1;
        held_state <= out_state;
      end
    end else begin
      held <= 1'b0;
    end
  end

  // Issues one state; returns 1 ns after the accepting edge.
  task automatic issue(input logic [127:0] d, input bit push);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_state = d;
    if (push) exp_q.push_back(ref_model(d));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int max_cycles);
    int c;
    c = 0;
    while (!out_valid && c < max_cycles) begin
      @(posedge clk); #1;
      c++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got out_valid=0 expected 1 within %0d cycles", max_cycles);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    bit hs;
    bit done;
    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);

    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; in_state = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_word_idx", 128'(word_idx), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    #3 rst = 1'b0;

    // All-zero input, then latency and word_idx sequence.
    issue(128'h0, 1'b1);
    chk("z_busy", 128'(busy), 128'd1);
    wait_done(10);
    chk("z_out", out_state, {16{8'h52}});
    @(posedge clk); #1;
    chk("z_idle", 128'(in_ready), 128'd1);

    issue(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    chk("lat_wi0", 128'(word_idx), 128'd0);
    chk("lat_ov0", 128'(out_valid), 128'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("lat_wi", 128'(word_idx), 128'(k));
      chk("lat_ov", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    chk("lat_ov4", 128'(out_valid), 128'd1);
    chk("lat_wi_wrap", 128'(word_idx), 128'd0);
    chk("lat_busy_done", 128'(busy), 128'd0);
    chk("byte15", 128'(out_state[127:120]), 128'h52);
    chk("byte14", 128'(out_state[119:112]), 128'h09);
    chk("byte0", 128'(out_state[7:0]), 128'hfb);
    @(posedge clk); #1;

    // Back-pressure: result held, second state refused until drained.
    out_ready = 1'b0;
    issue({16{8'h63}}, 1'b1);
    wait_done(10);
    in_valid = 1'b1;
    in_state = {16{8'hff}};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_out", out_state, 128'd0);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    exp_q.push_back(ref_model({16{8'hff}}));
    @(posedge clk); #1;
    chk("bp_idle", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", 128'(busy), 128'd1);
    wait_done(10);
    chk("bp_out2", out_state, {16{8'h7d}});
    @(posedge clk); #1;

    // Abort in the third SUB cycle.
    issue({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_idle", 128'(in_ready), 128'd1);
    chk("ab_wi", 128'(word_idx), 128'd0);
    chk("ab_out_state", out_state, {16{8'h7d}});
    // Abort together with in_valid in IDLE: nothing accepted.
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("ab_noaccept", 128'(busy), 128'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("ab_no_valid", 128'(out_valid), 128'd0);
    end

    // Asynchronous reset mid-SUB.
    issue({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 128'(busy), 128'd0);
    chk("ar_in_ready", 128'(in_ready), 128'd1);
    chk("ar_wi", 128'(word_idx), 128'd0);
    chk("ar_out_valid", 128'(out_valid), 128'd0);
    chk("ar_out_state", out_state, 128'd0);
    #2 rst = 1'b0;
    issue(128'h0, 1'b1);
    wait_done(10);
    chk("ar_after", out_state, {16{8'h52}});
    @(posedge clk); #1;

    // Random states with random sink back-pressure.
    for (int n = 0; n < 25; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      issue(d, 1'b1);
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        @(posedge clk); #1;
        if (hs) done = 1'b1;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout: got no handshake expected one for %h", d);
      end
    end
    out_ready = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
